// File: rtl/mc14500_pkg.sv
// Shared MC14500 definitions: the 4-bit instruction opcode set used by the
// sequencer and anything decoding the program stream.
package mc14500_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } opcode_e;

endpackage

// File: rtl/return_stack.sv
// Return-address stack for the instruction sequencer. Push wins over pop;
// a push when full or a pop when empty is ignored.
module return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                push_data,
    output logic [ADDR_W-1:0]                top,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Storage is rounded up to a power of two so every index value is in range.
    logic [ADDR_W-1:0] mem [0:(1 << IW) - 1];
    logic [DW-1:0]     count;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;

    assign top_idx = IW'(count - DW'(1));
    assign wr_idx  = IW'(count);
    assign full    = (count == DW'(STACK_DEPTH));
    assign empty   = (count == '0);
    assign top     = mem[top_idx];
    assign depth   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            count       <= count + DW'(1);
        end else if (pop && !empty) begin
            count <= count - DW'(1);
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// MC14500-style instruction sequencer: decodes JMP/RTN/SKZ/NOP flags and
// drives program counter loads, with a one-instruction skip and return stack.
module instruction_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [ADDR_W-1:0]                pc_addr,
    input  logic [3:0]                       opcode,
    input  logic [ADDR_W-1:0]                operand,
    input  logic                             rr,
    output logic                             pc_write,
    output logic [ADDR_W-1:0]                pc_target,
    output logic                             squash,
    output logic                             jmp_flag,
    output logic                             rtn_flag,
    output logic                             flag_o,
    output logic                             flag_f,
    output logic                             stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth
);

    opcode_e           op;
    logic              skip_q;
    logic              err_q;
    logic              active;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] pc_inc;

    assign op        = opcode_e'(opcode);
    assign pc_inc    = pc_addr + ADDR_W'(1);
    assign active    = !reset && run && !skip_q;
    assign squash    = !reset && skip_q;
    assign stack_err = err_q;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .depth     (depth)
    );

    // A stall reloads the current address so the PC holds without a separate enable.
    always_comb begin
        pc_write  = 1'b0;
        pc_target = pc_inc;
        jmp_flag  = 1'b0;
        rtn_flag  = 1'b0;
        flag_o    = 1'b0;
        flag_f    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!reset && !run) begin
            pc_write  = 1'b1;
            pc_target = pc_addr;
        end else if (active) begin
            case (op)
                JMP: begin
                    pc_write  = 1'b1;
                    pc_target = operand;
                    jmp_flag  = 1'b1;
                    push      = !full;
                end
                RTN: begin
                    rtn_flag = 1'b1;
                    if (!empty) begin
                        pc_write  = 1'b1;
                        pc_target = top;
                        pop       = 1'b1;
                    end
                end
                NOPO:    flag_o = 1'b1;
                NOPF:    flag_f = 1'b1;
                default: ;
            endcase
        end
    end

    // Any instruction that passes with run=1 consumes a pending skip.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (run) begin
            skip_q <= !skip_q && (op == SKZ) && !rr;
            if (active && (((op == JMP) && full) || ((op == RTN) && empty))) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
